pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Registered program-counter unit that generates the fetch address every cycle.
- Generalised next-address logic: configurable address and word widths, six branch conditions, and register-indirect jumps.
- Adds fetch-ready handshake, stall, redirect/flush generation, and taken/redirect statistics counters.
- Sits between the EX stage (redirect source) and the instruction-memory port (fetch sink).

Parameters:
- ADDR_W, 32, PC width in bits.
- INSTR_BYTES, 4, bytes per instruction; power of 2, at least 1; SH = log2(INSTR_BYTES).
- JUMP_W, 26, width of the jump index field.
- RESET_VEC, 0, PC value after reset.
- TRAP_VEC, 32'h0000_0080, misalign trap target; used only with the optional feature.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_ready  in  1  imem accepts pc when pc_valid is high.
- stall  in  1  hazard-unit freeze of the fetch stage.
- ex_valid  in  1  EX holds a valid control-flow instruction.
- ex_pc_src  in  2  00 sequential, 01 conditional branch, 10 direct jump, 11 jump-register.
- ex_br_cond  in  3  0 EQ, 1 NE, 2 LT (signed), 3 GE (signed), 4 LTU, 5 GEU; 6 and 7 are never taken.
- ex_src_a, ex_src_b  in  ADDR_W  compare operands.
- ex_pc  in  ADDR_W  PC of the EX instruction.
- ex_offset  in  ADDR_W  signed branch offset, in instructions.
- ex_jump_index  in  JUMP_W  direct-jump index field.
- ex_jr_target  in  ADDR_W  register jump target.
- pc  out  ADDR_W  current fetch address.
- pc_valid  out  1  pc is a valid fetch request.
- flush  out  1  combinational; high in the cycle a redirect is taken.
- taken_cnt  out  CNT_W  count of taken conditional branches.
- redirect_cnt  out  CNT_W  count of all taken redirects.
- misalign  out  1  misaligned jump-register target; used only with the optional feature.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_VEC, FSM state=BOOT, pc_valid=0.
  - taken_cnt=0, redirect_cnt=0, misalign=0.
  - Reset overrides every other input, including a redirect in flight.
- FSM states:
  - BOOT: pc_valid=0. Moves to RUN on the next edge unconditionally. A redirect in BOOT is still applied.
  - RUN: pc_valid=1. A taken redirect keeps the FSM in RUN.
- Address arithmetic (all modulo 2^ADDR_W, wrap-around silent):
  - seq = pc + INSTR_BYTES.
  - link = ex_pc + INSTR_BYTES.
  - br_tgt = link + (ex_offset << SH).
  - j_tgt = {link[ADDR_W-1 : JUMP_W+SH], ex_jump_index, SH zero bits}.
  - jr_tgt = ex_jr_target with its low SH bits forced to 0.
- take, computed combinationally from ex_pc_src:
  - 01: take = ex_valid && condition true.
  - 10 or 11: take = ex_valid.
  - 00: take = 0.
- Next-pc priority per edge: rst > take (load target) > stall or !fetch_ready (hold) > BOOT (hold) > RUN (pc=seq).
- Redirect rules:
  - A redirect is never lost: it loads pc even while stalled or while fetch_ready=0.
  - flush = take && !rst.
- Counters, updated on take:
  - redirect_cnt += 1.
  - taken_cnt += 1 only when ex_pc_src=01.
  - Both saturate at all-ones; they do not wrap.
- Latency: one cycle from take to the new pc appearing on the output.
- pc is held stable while pc_valid && !fetch_ready.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - If a jump-register is taken and ex_jr_target[SH-1:0] != 0, pc loads TRAP_VEC instead of the target.
  - misalign pulses high for exactly one cycle, registered, visible in the cycle after the take.
  - flush and redirect_cnt behave as for any taken redirect.
- Undefined:
  - Low bits are silently masked.
  - misalign is tied to 0.

Test Plan:
- Reset/boot: assert rst 2 cycles, then release with fetch_ready=1 -> pc=0 and pc_valid=0 for 1 cycle; then pc=0 with pc_valid=1; then pc steps 4, 8, 12.
- Handshake: fetch_ready=0 for 3 cycles at pc=0x10 -> pc holds 0x10 with pc_valid=1; resumes at 0x14.
- Branch EQ/NE: ex_pc=0x40, offset=-2, a=b=5:
  - EQ -> flush=1; next pc=0x3C; taken_cnt=1.
  - NE with the same operands -> no flush; pc sequential.
- Signed vs unsigned: a=0xFFFFFFFF, b=1:
  - LT taken.
  - LTU not taken.
  - GEU taken, next pc=br_tgt.
- Stall+redirect: stall=1 and a jump with ex_pc=0x1000_0000, index=0x10 -> pc=0x1000_0040 next cycle despite stall; redirect_cnt increments.
- Misalign: with PC_ALIGN_CHECK_EN, jump-register to 0x203 -> pc=TRAP_VEC and misalign pulses for 1 cycle. Without the macro -> pc=0x200 and misalign=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program-counter unit that issues one fetch address per cycle.
//
// The next PC is chosen from EX-stage redirects (conditional branch, direct jump or
// jump-register), a hold (stall, fetch back-pressure or boot), or the sequential
// successor. Saturating statistics counters track taken conditional branches and
// all taken redirects.
//
// Optional feature, enabled by defining PC_ALIGN_CHECK_EN:
//   A taken jump-register whose target has nonzero low SH bits is diverted to
//   TRAP_VEC, and misalign pulses for one cycle after the take. When the macro is
//   not defined, the low bits are silently masked and misalign stays 0.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   fetch_ready         imem accepts pc this cycle
//   stall               hazard-unit freeze of the fetch stage
//   ex_valid            EX holds a valid control-flow instruction
//   ex_pc_src           00 seq, 01 cond branch, 10 direct jump, 11 jump-register
//   ex_br_cond          0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6/7 never taken
//   ex_src_a, ex_src_b  compare operands
//   ex_pc               PC of the EX instruction
//   ex_offset           signed branch offset in instructions
//   ex_jump_index       direct-jump index field
//   ex_jr_target        register jump target
//   pc, pc_valid        fetch request
//   flush               combinational, high in the cycle a redirect is taken
//   taken_cnt           saturating count of taken conditional branches
//   redirect_cnt        saturating count of all taken redirects
//   misalign            one-cycle misaligned jump-register pulse (optional feature)
module pc_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_BYTES = 4,
    parameter int                JUMP_W      = 26,
    parameter logic [ADDR_W-1:0] RESET_VEC   = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(32'h0000_0080),
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_ready,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic [1:0]        ex_pc_src,
    input  logic [2:0]        ex_br_cond,
    input  logic [ADDR_W-1:0] ex_src_a,
    input  logic [ADDR_W-1:0] ex_src_b,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic [ADDR_W-1:0] ex_offset,
    input  logic [JUMP_W-1:0] ex_jump_index,
    input  logic [ADDR_W-1:0] ex_jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              flush,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  redirect_cnt,
    output logic              misalign
);

    localparam int SH = $clog2(INSTR_BYTES);

    // Low address bits that must be zero for an instruction-aligned address.
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(INSTR_BYTES - 1);
    // Bits replaced by {jump_index, SH zeros} in a direct jump.
    localparam logic [ADDR_W-1:0] JIDX_MASK = {ADDR_W{1'b1}} >> (ADDR_W - JUMP_W - SH);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(INSTR_BYTES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;
    logic              misalign_q, misalign_d;

    logic              cond_true_s;
    logic              take_s;
    logic              align_trap_s;
    logic [ADDR_W-1:0] seq_pc_s;
    logic [ADDR_W-1:0] link_s;
    logic [ADDR_W-1:0] br_tgt_s;
    logic [ADDR_W-1:0] j_tgt_s;
    logic [ADDR_W-1:0] jr_tgt_s;
    logic [ADDR_W-1:0] redirect_tgt_s;

    assign seq_pc_s = pc_q + STEP;
    assign link_s   = ex_pc + STEP;
    assign br_tgt_s = link_s + (ex_offset << SH);
    // Keep the upper link bits above the index field, splice in the index.
    assign j_tgt_s  = (link_s & ~JIDX_MASK) | (ADDR_W'(ex_jump_index) << SH);
    assign jr_tgt_s = ex_jr_target & ~LOW_MASK;

`ifdef PC_ALIGN_CHECK_EN
    assign align_trap_s = take_s && (ex_pc_src == 2'b11) &&
                          ((ex_jr_target & LOW_MASK) != {ADDR_W{1'b0}});
`else
    assign align_trap_s = 1'b0;
`endif

    // Branch condition evaluation.
    always_comb begin
        cond_true_s = 1'b0;
        case (ex_br_cond)
            3'd0:    cond_true_s = (ex_src_a == ex_src_b);
            3'd1:    cond_true_s = (ex_src_a != ex_src_b);
            3'd2:    cond_true_s = ($signed(ex_src_a) <  $signed(ex_src_b));
            3'd3:    cond_true_s = ($signed(ex_src_a) >= $signed(ex_src_b));
            3'd4:    cond_true_s = (ex_src_a <  ex_src_b);
            3'd5:    cond_true_s = (ex_src_a >= ex_src_b);
            default: cond_true_s = 1'b0;
        endcase
    end

    // Redirect decision from the EX control-flow source.
    always_comb begin
        take_s = 1'b0;
        case (ex_pc_src)
            2'b01:   take_s = ex_valid && cond_true_s;
            2'b10:   take_s = ex_valid;
            2'b11:   take_s = ex_valid;
            default: take_s = 1'b0;
        endcase
    end

    // Redirect target selection.
    always_comb begin
        redirect_tgt_s = seq_pc_s;
        case (ex_pc_src)
            2'b01:   redirect_tgt_s = br_tgt_s;
            2'b10:   redirect_tgt_s = j_tgt_s;
            2'b11:   redirect_tgt_s = align_trap_s ? TRAP_VEC : jr_tgt_s;
            default: redirect_tgt_s = seq_pc_s;
        endcase
    end

    // Next PC and FSM state; a redirect wins over stall and back-pressure.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (take_s) begin
            pc_d = redirect_tgt_s;
        end else if (stall || !fetch_ready) begin
            pc_d = pc_q;
        end else if (state_q == ST_BOOT) begin
            pc_d = pc_q;
        end else begin
            pc_d = seq_pc_s;
        end
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // Saturating statistics counters and the misalign pulse source.
    always_comb begin
        taken_cnt_d    = taken_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        misalign_d     = align_trap_s;
        if (take_s && (redirect_cnt_q != CNT_MAX)) begin
            redirect_cnt_d = redirect_cnt_q + CNT_ONE;
        end else begin
            redirect_cnt_d = redirect_cnt_q;
        end
        if (take_s && (ex_pc_src == 2'b01) && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + CNT_ONE;
        end else begin
            taken_cnt_d = taken_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_VEC;
            state_q        <= ST_BOOT;
            taken_cnt_q    <= {CNT_W{1'b0}};
            redirect_cnt_q <= {CNT_W{1'b0}};
            misalign_q     <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            state_q        <= state_d;
            taken_cnt_q    <= taken_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
            misalign_q     <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = (state_q == ST_RUN);
    assign flush        = take_s && !rst;
    assign taken_cnt    = taken_cnt_q;
    assign redirect_cnt = redirect_cnt_q;
    assign misalign     = misalign_q;

endmodule
